// File: rtl/result_display_driver.sv
// Purpose: converts an 8-bit result to 3-digit BCD and scans it onto a 3-digit common-cathode 7-segment display.
// Latency: bcd_valid_o pulses 9 enabled cycles after the accepting edge; seg_o is combinational from registered state.
// Backpressure: ready_o is high only in IDLE; valids seen while busy are dropped, not queued.
module result_display_driver #(
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  result_i,
  input  logic        result_valid_i,
  output logic        ready_o,
  output logic [11:0] bcd_o,
  output logic        bcd_valid_o,
  output logic [6:0]  seg_o,
  output logic [2:0]  digit_sel_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Counter width kept at least 1 bit so SCAN_DIV = 1 still elaborates.
  localparam int unsigned     CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   SCAN_LAST = CW'(SCAN_DIV - 1);

  state_t        state_q, state_d;
  logic [7:0]    bin_q, bin_d;
  logic [11:0]   scratch_q, scratch_d;
  logic [3:0]    iter_q, iter_d;
  logic [11:0]   bcd_q, bcd_d;
  logic          bcd_valid_q, bcd_valid_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    digit_sel_q, digit_sel_d;
  logic [11:0]   scratch_adj;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
  function automatic logic [11:0] dabble_adjust(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Active-high common-cathode patterns, bit 0 = segment a.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign scratch_adj = dabble_adjust(scratch_q);

  // Conversion FSM: accept in IDLE, eight adjust-and-shift steps, publish in DONE.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    scratch_d   = scratch_q;
    iter_d      = iter_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (result_valid_i) begin
            bin_d     = result_i;
            scratch_d = 12'd0;
            iter_d    = 4'd0;
            state_d   = CONVERT;
          end
        end
        CONVERT: begin
          {scratch_d, bin_d} = {scratch_adj[10:0], bin_q, 1'b0};
          iter_d             = iter_q + 4'd1;
          if (iter_q == 4'd7) begin
            state_d = DONE;
          end
        end
        DONE: begin
          bcd_d       = scratch_q;
          bcd_valid_d = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Scan timer: each digit stays selected for SCAN_DIV enabled cycles, independent of the FSM.
  always_comb begin
    scan_cnt_d  = scan_cnt_q;
    digit_sel_d = digit_sel_q;
    if (ena) begin
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_d  = '0;
        digit_sel_d = {digit_sel_q[1:0], digit_sel_q[2]};
      end else begin
        scan_cnt_d = scan_cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset leaves the display showing a single "0" on the units digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bin_q       <= 8'd0;
      scratch_q   <= 12'd0;
      iter_q      <= 4'd0;
      bcd_q       <= 12'd0;
      bcd_valid_q <= 1'b0;
      scan_cnt_q  <= '0;
      digit_sel_q <= 3'b001;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      scratch_q   <= scratch_d;
      iter_q      <= iter_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  // Segment decode with leading-zero blanking; units is never blanked so 0 still shows.
  always_comb begin
    logic [3:0] nibble;
    logic       blank;
    nibble = bcd_q[3:0];
    blank  = 1'b0;
    case (digit_sel_q)
      3'b010: begin
        nibble = bcd_q[7:4];
        blank  = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      3'b100: begin
        nibble = bcd_q[11:8];
        blank  = (bcd_q[11:8] == 4'd0);
      end
      default: begin
        nibble = bcd_q[3:0];
        blank  = 1'b0;
      end
    endcase
    seg_o = blank ? 7'h00 : seg_decode(nibble);
  end

  assign ready_o     = (state_q == IDLE);
  assign bcd_o       = bcd_q;
  assign bcd_valid_o = bcd_valid_q & ena;
  assign digit_sel_o = digit_sel_q;

endmodule
